// File: rtl/upconverter_nco_pkg.sv
// Shared definitions for the upconverter NCO: mix modes, pipeline latency,
// saturation counter width and the sine-table rounding helper.
package upconverter_nco_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    USB    = 2'b01,
    LSB    = 2'b10
  } mode_e;

  localparam int unsigned PIPE_LATENCY  = 5;
  localparam int unsigned SAT_CNT_WIDTH = 16;

  // Round to nearest, ties away from zero; used only while building the table.
  function automatic int round_coef(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  // Mode 11 is treated as bypass.
  function automatic mode_e decode_mode(logic [1:0] m);
    case (m)
      2'b01:   return USB;
      2'b10:   return LSB;
      default: return BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/upconverter_nco_lut.sv
// Phase accumulator plus full-wave cos/sin table; coefficients are registered
// one enabled cycle after the accumulator value that addresses them.
module upconverter_nco_lut
  import upconverter_nco_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int COEF_WIDTH     = 18
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [PHASE_WIDTH-1:0]       freq_word_i,
  input  logic                         freq_load_i,
  input  logic                         phase_reset_i,
  output logic signed [COEF_WIDTH-1:0] cos_o,
  output logic signed [COEF_WIDTH-1:0] sin_o
);

  localparam int unsigned DEPTH  = 2 ** LUT_ADDR_WIDTH;
  localparam real         AMP    = (2.0 ** (COEF_WIDTH - 1)) - 1.0;
  localparam real         TWO_PI = 6.283185307179586;

  logic signed [COEF_WIDTH-1:0] cos_rom [DEPTH];
  logic signed [COEF_WIDTH-1:0] sin_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam real ANG = TWO_PI * real'(g) / real'(DEPTH);
    assign cos_rom[g] = COEF_WIDTH'(round_coef(AMP * $cos(ANG)));
    assign sin_rom[g] = COEF_WIDTH'(round_coef(AMP * $sin(ANG)));
  end

  logic [PHASE_WIDTH-1:0]    acc_q, acc_d, fw_q, fw_d;
  logic                      pend_q, pend_d;
  logic [LUT_ADDR_WIDTH-1:0] addr;
  logic signed [COEF_WIDTH-1:0] cos_q, sin_q;

  assign addr  = acc_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
  assign cos_o = cos_q;
  assign sin_o = sin_q;

  // A phase reset arriving on an enabled cycle takes effect at once; otherwise
  // it waits, and the accumulator always adds the previously captured word.
  always_comb begin
    acc_d  = acc_q;
    pend_d = pend_q | phase_reset_i;
    fw_d   = freq_load_i ? freq_word_i : fw_q;
    if (en_i) begin
      acc_d  = (pend_q || phase_reset_i) ? '0 : acc_q + fw_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      fw_q   <= '0;
      pend_q <= 1'b0;
      cos_q  <= '0;
      sin_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      fw_q   <= fw_d;
      pend_q <= pend_d;
      if (en_i) begin
        cos_q <= cos_rom[addr];
        sin_q <= sin_rom[addr];
      end
    end
  end

endmodule

// File: rtl/upconverter_nco.sv
// Complex I/Q upconverter: NCO mix, half-up rounding, gain shift, saturation.
// Define UPCONVERTER_NCO_SAT_COUNT_EN to build the saturation event counter.
module upconverter_nco
  import upconverter_nco_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int COEF_WIDTH     = 18
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [WIDTH-1:0]         i_inph_data,
  input  logic [WIDTH-1:0]         i_quad_data,
  input  logic                     i_ready,
  output logic                     o_ready,
  input  logic [PHASE_WIDTH-1:0]   i_freq_word,
  input  logic                     i_freq_load,
  input  logic                     i_phase_reset,
  input  logic [1:0]               i_mode,
  input  logic [1:0]               i_gain_shift,
  input  logic                     i_sat_clear,
  output logic [WIDTH-1:0]         o_inph_data,
  output logic [WIDTH-1:0]         o_quad_data,
  output logic                     o_sat,
  output logic [SAT_CNT_WIDTH-1:0] o_sat_count
);

  localparam int unsigned PW   = WIDTH + COEF_WIDTH;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned RW   = WIDTH + 5;
  localparam int unsigned DROP = COEF_WIDTH - 1;
  // Sample context (data, mode, gain) rides alongside the first three stages.
  localparam int unsigned DL   = PIPE_LATENCY - 2;

  localparam logic signed [SW-1:0]    RND  = SW'(1) << (COEF_WIDTH - 2);
  localparam logic signed [RW-1:0]    MAXV = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0]    MINV = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

  logic                         en;
  logic signed [COEF_WIDTH-1:0] cos_w, sin_w;

  assign en      = i_ready;
  assign o_ready = i_ready;

  upconverter_nco_lut #(
    .PHASE_WIDTH   (PHASE_WIDTH),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .COEF_WIDTH    (COEF_WIDTH)
  ) u_lut (
    .clk_i        (i_clock),
    .rst_i        (i_reset),
    .en_i         (en),
    .freq_word_i  (i_freq_word),
    .freq_load_i  (i_freq_load),
    .phase_reset_i(i_phase_reset),
    .cos_o        (cos_w),
    .sin_o        (sin_w)
  );

  logic signed [WIDTH-1:0] xi_q [DL];
  logic signed [WIDTH-1:0] xq_q [DL];
  mode_e                   mode_q [DL];
  logic [1:0]              gain_q [DL];

  logic signed [PW-1:0]    ic_q, qs_q, is_q, qc_q, ic_d, qs_d, is_d, qc_d;
  logic signed [SW-1:0]    si_q, sq_q, si_d, sq_d, rnd_i, rnd_q;
  logic signed [RW-1:0]    ri_q, rq_q, ri_d, rq_d;
  logic signed [WIDTH-1:0] oi_q, oq_q, oi_d, oq_d;
  logic                    sat_q, sat_d;

  always_comb begin
    ic_d = PW'(xi_q[0]) * PW'(cos_w);
    qs_d = PW'(xq_q[0]) * PW'(sin_w);
    is_d = PW'(xi_q[0]) * PW'(sin_w);
    qc_d = PW'(xq_q[0]) * PW'(cos_w);

    si_d = '0;
    sq_d = '0;
    case (mode_q[1])
      USB: begin
        si_d = SW'(ic_q) - SW'(qs_q);
        sq_d = SW'(is_q) + SW'(qc_q);
      end
      LSB: begin
        si_d = SW'(ic_q) + SW'(qs_q);
        sq_d = SW'(qc_q) - SW'(is_q);
      end
      default: ;
    endcase

    rnd_i = (si_q + RND) >>> DROP;
    rnd_q = (sq_q + RND) >>> DROP;
    ri_d  = RW'(rnd_i) <<< gain_q[2];
    rq_d  = RW'(rnd_q) <<< gain_q[2];
    if (mode_q[2] == BYPASS) begin
      ri_d = RW'(xi_q[2]);
      rq_d = RW'(xq_q[2]);
    end

    oi_d  = WIDTH'(ri_q);
    oq_d  = WIDTH'(rq_q);
    sat_d = 1'b0;
    if (ri_q > MAXV)      begin oi_d = MAXW; sat_d = 1'b1; end
    else if (ri_q < MINV) begin oi_d = MINW; sat_d = 1'b1; end
    if (rq_q > MAXV)      begin oq_d = MAXW; sat_d = 1'b1; end
    else if (rq_q < MINV) begin oq_d = MINW; sat_d = 1'b1; end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned s = 0; s < DL; s++) begin
        xi_q[s]   <= '0;
        xq_q[s]   <= '0;
        mode_q[s] <= BYPASS;
        gain_q[s] <= '0;
      end
      {ic_q, qs_q, is_q, qc_q} <= '0;
      {si_q, sq_q}             <= '0;
      {ri_q, rq_q}             <= '0;
      {oi_q, oq_q}             <= '0;
      sat_q                    <= 1'b0;
    end else if (en) begin
      xi_q[0]   <= $signed(i_inph_data);
      xq_q[0]   <= $signed(i_quad_data);
      mode_q[0] <= decode_mode(i_mode);
      gain_q[0] <= i_gain_shift;
      for (int unsigned s = 1; s < DL; s++) begin
        xi_q[s]   <= xi_q[s-1];
        xq_q[s]   <= xq_q[s-1];
        mode_q[s] <= mode_q[s-1];
        gain_q[s] <= gain_q[s-1];
      end
      ic_q  <= ic_d;
      qs_q  <= qs_d;
      is_q  <= is_d;
      qc_q  <= qc_d;
      si_q  <= si_d;
      sq_q  <= sq_d;
      ri_q  <= ri_d;
      rq_q  <= rq_d;
      oi_q  <= oi_d;
      oq_q  <= oq_d;
      sat_q <= sat_d;
    end
  end

  assign o_inph_data = oi_q;
  assign o_quad_data = oq_q;
  assign o_sat       = sat_q;

`ifdef UPCONVERTER_NCO_SAT_COUNT_EN
  logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Counts with the edge that loads a saturated sample into the output.
  always_comb begin
    cnt_d = cnt_q;
    if (i_sat_clear)                         cnt_d = '0;
    else if (en && sat_d && (cnt_q != '1))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_sat_count = cnt_q;
`else
  logic unused_sat_clear;
  assign unused_sat_clear = i_sat_clear;
  assign o_sat_count      = '0;
`endif

endmodule

// File: doc/upconverter_nco.md
UPCONVERTER_NCO -- requirements
Module: upconverter_nco

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning I/Q sample width (signed two's complement).
REQ-002 SHALL have parameter PHASE_WIDTH, default 32, meaning NCO phase accumulator width.
REQ-003 SHALL have parameter LUT_ADDR_WIDTH, default 10, meaning log2 of full-wave sine/cosine table depth.
REQ-004 SHALL have parameter COEF_WIDTH, default 18, meaning signed sine/cosine coefficient width.
REQ-005 SHALL have port i_clock  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports i_inph_data / i_quad_data  input  WIDTH each  baseband I/Q sample.
REQ-008 SHALL have port i_ready  input  1  clock enable; pipeline, NCO and counter advance only when 1.
REQ-009 SHALL have port o_ready  output  1  equal to i_ready, combinational; the block never stalls.
REQ-010 SHALL have port i_freq_word  input  PHASE_WIDTH  unsigned phase increment per enabled cycle.
REQ-011 SHALL have port i_freq_load  input  1  pulse that captures i_freq_word.
REQ-012 SHALL have port i_phase_reset  input  1  pulse that zeroes the phase accumulator.
REQ-013 SHALL have port i_mode  input  2  mode: 00 bypass, 01 upper-sideband mix, 10 lower-sideband mix, 11 bypass.
REQ-014 SHALL have port i_gain_shift  input  2  post-mix left shift of 0..3 bits.
REQ-015 SHALL have port i_sat_clear  input  1  synchronous clear of o_sat_count.
REQ-016 SHALL have ports o_inph_data / o_quad_data  output  WIDTH each  upconverted I/Q sample.
REQ-017 SHALL have port o_sat  output  1  set when the current output sample saturated on either channel.
REQ-018 SHALL have port o_sat_count  output  16  saturation event counter.

Function
REQ-019 SHALL capture i_freq_word on any cycle with i_freq_load=1, regardless of i_ready, and use it from the next enabled increment.
REQ-020 SHALL, on each enabled cycle, load the accumulator with 0 if a phase reset is pending, else with accumulator+freq word modulo 2^PHASE_WIDTH.
REQ-021 SHALL latch i_phase_reset until the next enabled cycle; a phase reset with a simultaneous freq load gives phase 0, and the new word applies from the following enabled cycle.
REQ-022 SHALL address the table with the accumulator's top LUT_ADDR_WIDTH bits; amplitude is 2^(COEF_WIDTH-1)-1, and address 0 gives cos=max, sin=0.
REQ-023 SHALL, in mode 01, compute I=xi*cos-xq*sin and Q=xi*sin+xq*cos; in mode 10, I=xi*cos+xq*sin and Q=xq*cos-xi*sin.
REQ-024 SHALL form full-precision products (WIDTH+COEF_WIDTH bits) and a sum one bit wider, with no intermediate truncation.
REQ-025 SHALL round half-up by adding 2^(COEF_WIDTH-2) and dropping COEF_WIDTH-1 LSBs, then shift left by i_gain_shift.
REQ-026 SHALL saturate each channel to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and set o_sat for that sample.
REQ-027 SHALL use a fixed latency of 5 enabled cycles, input to output, in all modes; bypass is delay-matched, unrounded and unshifted.
REQ-028 SHALL sample i_mode and i_gain_shift with the input data and carry them down the pipeline, so mode changes never corrupt in-flight samples.
REQ-029 SHALL hold outputs and all state on cycles with i_ready=0.
REQ-030 SHALL increment o_sat_count once per enabled output sample with o_sat=1, stick at 0xFFFF, and let i_sat_clear win over a simultaneous increment.

Reset
REQ-031 SHALL, while i_reset=1, drive o_inph_data, o_quad_data, o_sat and o_sat_count to 0.
REQ-032 SHALL, while i_reset=1, clear the accumulator, freq word register, pending phase reset and all pipeline registers to 0; in-flight samples are discarded.

Configuration
REQ-033 SHALL implement the saturation counter only when UPCONVERTER_NCO_SAT_COUNT_EN is defined; otherwise o_sat_count is constant 0 and i_sat_clear is ignored. o_sat is present in both builds.

Structure
REQ-034 SHALL take the mode enum (BYPASS, USB, LSB), the pipeline latency constant (5) and the sat-counter width (16) from package upconverter_nco_pkg.
REQ-035 SHALL put the phase accumulator and table in one sub-module, upconverter_nco_lut, with 1 enabled cycle from address to registered cos/sin.

Verification
REQ-036 Reset: assert i_reset mid-stream -> all outputs 0 immediately; first valid output 5 enabled cycles after release.
REQ-037 Bypass: mode 00, I=0x1234, Q=0xFF00, gain 3 -> I=0x1234, Q=0xFF00 after 5 enabled cycles.
REQ-038 DC mix: freq 0, phase reset, mode 01, I=1000, Q=0 -> I=1000, Q=0.
REQ-039 Quarter-rate: freq 2^30, I=1000, Q=0 -> I 1000,0,-1000,0 and Q 0,1000,0,-1000; mode 10 negates the Q sequence.
REQ-040 Saturation: freq 0, I=Q=0x7FFF, gain 3 -> I=0x7FFF, o_sat=1, count +1 per enabled sample, sticks at 0xFFFF; i_sat_clear -> 0.
REQ-041 Stall: i_ready pattern 1,0,1,0 -> output sequence and NCO phase identical to the i_ready=1 run, outputs frozen while i_ready=0.
